// File: rtl/estimador_zhat_collector_if.sv
// Estimator ap_ctrl_hs handshake and downstream state-vector bundle for estimador_zhat_collector.
// The range_err lane exists only when ZHAT_RANGE_CHECK_EN is defined.
interface estimador_zhat_collector_if #(
  parameter int W = 21
);
  logic         est_ap_start;
  logic         est_ap_ready;
  logic         est_ap_done;
  logic [W-1:0] zhat_next_0;
  logic [W-1:0] zhat_next_1;
  logic [W-1:0] zhat_next_2;
  logic         zhat_next_0_ap_vld;
  logic         zhat_next_1_ap_vld;
  logic         zhat_next_2_ap_vld;
  logic [W-1:0] state_0;
  logic [W-1:0] state_1;
  logic [W-1:0] state_2;
  logic         state_valid;
  logic         state_ready;
  logic [2:0]   missing;
`ifdef ZHAT_RANGE_CHECK_EN
  logic [2:0]   range_err;

  modport master (
    output est_ap_start, state_0, state_1, state_2, state_valid, missing, range_err,
    input  est_ap_ready, est_ap_done, zhat_next_0, zhat_next_1, zhat_next_2,
           zhat_next_0_ap_vld, zhat_next_1_ap_vld, zhat_next_2_ap_vld, state_ready
  );
  modport slave (
    input  est_ap_start, state_0, state_1, state_2, state_valid, missing, range_err,
    output est_ap_ready, est_ap_done, zhat_next_0, zhat_next_1, zhat_next_2,
           zhat_next_0_ap_vld, zhat_next_1_ap_vld, zhat_next_2_ap_vld, state_ready
  );
`else
  modport master (
    output est_ap_start, state_0, state_1, state_2, state_valid, missing,
    input  est_ap_ready, est_ap_done, zhat_next_0, zhat_next_1, zhat_next_2,
           zhat_next_0_ap_vld, zhat_next_1_ap_vld, zhat_next_2_ap_vld, state_ready
  );
  modport slave (
    input  est_ap_start, state_0, state_1, state_2, state_valid, missing,
    output est_ap_ready, est_ap_done, zhat_next_0, zhat_next_1, zhat_next_2,
           zhat_next_0_ap_vld, zhat_next_1_ap_vld, zhat_next_2_ap_vld, state_ready
  );
`endif
endinterface

// File: rtl/estimador_zhat_collector.sv
// Starts the estimator per sample tick, collects the three zhat_next lanes and presents them
// downstream with missing/timeout/overrun tracking. Optional clamp check: ZHAT_RANGE_CHECK_EN.
module estimador_zhat_collector #(
  parameter int W           = 21,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 8
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        trig,
  estimador_zhat_collector_if.master  bus,
  output logic                        err_timeout,
  output logic                        err_overrun,
  output logic                        busy
);

  typedef enum logic [1:0] {IDLE, START, COLLECT, PRESENT} state_t;

  // Assert asynchronously, release on the second ap_clk edge.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) rst_sync <= '0;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic [W-1:0]     zin [3];
  logic [2:0]       vld;
  state_t           state_q, state_d;
  logic [2:0]       got_q, got_d;
  logic [W-1:0]     lane_q [3];
  logic [W-1:0]     lane_d [3];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_hit, to_set, ov_set;
  logic             start_q, valid_q, busy_q, err_to_q, err_ov_q;
  logic [2:0]       missing_q;

  assign zin[0] = bus.zhat_next_0;
  assign zin[1] = bus.zhat_next_1;
  assign zin[2] = bus.zhat_next_2;
  assign vld    = {bus.zhat_next_2_ap_vld, bus.zhat_next_1_ap_vld, bus.zhat_next_0_ap_vld};

  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    state_d = state_q;
    got_d   = got_q;
    lane_d  = lane_q;
    cnt_d   = cnt_q;
    to_set  = 1'b0;
    ov_set  = trig && (state_q != IDLE);
    if (state_q == START || state_q == COLLECT) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int unsigned k = 0; k < 3; k++) begin
        if (vld[k]) begin
          lane_d[k] = zin[k];
          got_d[k]  = 1'b1;
        end
      end
    end
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = START;
          got_d   = '0;
          cnt_d   = '0;
        end
      end
      START: begin
        // Completion in the accept cycle wins over both the timeout and the move to COLLECT.
        if (bus.est_ap_ready && bus.est_ap_done) begin
          state_d = PRESENT;
        end else if (timeout_hit) begin
          state_d = PRESENT;
          to_set  = 1'b1;
        end else if (bus.est_ap_ready) begin
          state_d = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.est_ap_done) begin
          state_d = PRESENT;
        end else if (timeout_hit) begin
          state_d = PRESENT;
          to_set  = 1'b1;
        end
      end
      PRESENT: begin
        if (bus.state_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ZHAT_RANGE_CHECK_EN
  logic [2:0] range_d, range_q;

  function automatic logic out_of_range(input logic [W-1:0] v, input int lim);
    int s;
    s = int'($signed(v));
    return (s > lim) || (s < -lim);
  endfunction

  always_comb begin
    range_d    = '0;
    range_d[0] = got_d[0] && out_of_range(lane_d[0], 163840);
    range_d[1] = got_d[1] && out_of_range(lane_d[1], 102944);
    range_d[2] = got_d[2] && out_of_range(lane_d[2], 16384);
  end

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n)                                          range_q <= '0;
    else if (state_d != PRESENT)                         range_q <= '0;
    else if (state_q != PRESENT)                         range_q <= range_d;
  end
  assign bus.range_err = range_q;
`endif

  always_ff @(posedge ap_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      got_q     <= '0;
      cnt_q     <= '0;
      for (int unsigned k = 0; k < 3; k++) lane_q[k] <= '0;
      start_q   <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      missing_q <= '0;
      err_to_q  <= 1'b0;
      err_ov_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      got_q   <= got_d;
      cnt_q   <= cnt_d;
      for (int unsigned k = 0; k < 3; k++) lane_q[k] <= lane_d[k];
      start_q <= (state_d == START);
      valid_q <= (state_d == PRESENT);
      busy_q  <= (state_d != IDLE);
      // Missing flags freeze on PRESENT entry and include strobes landing with ap_done.
      if (state_d != PRESENT)      missing_q <= '0;
      else if (state_q != PRESENT) missing_q <= ~got_d;
      if (to_set) err_to_q <= 1'b1;
      if (ov_set) err_ov_q <= 1'b1;
    end
  end

  assign bus.est_ap_start = start_q;
  assign bus.state_valid  = valid_q;
  assign bus.missing      = missing_q;
  assign bus.state_0      = lane_q[0];
  assign bus.state_1      = lane_q[1];
  assign bus.state_2      = lane_q[2];
  assign err_timeout      = err_to_q;
  assign err_overrun      = err_ov_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_estimador_zhat_collector.sv
// Directed bench for estimador_zhat_collector: table of estimator runs plus hand-written
// timeout, backpressure/overrun and asynchronous-reset sequences.
module tb_estimador_zhat_collector;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  logic trig = 1'b0;
  logic err_timeout, err_overrun, busy;

  int errors = 0;
  int checks = 0;

  estimador_zhat_collector_if #(.W(21)) bus ();

  estimador_zhat_collector #(.W(21), .TIMEOUT_CYC(64), .CNT_W(8)) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .trig        (trig),
    .bus         (bus),
    .err_timeout (err_timeout),
    .err_overrun (err_overrun),
    .busy        (busy)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  typedef struct {
    logic [2:0]  mask;
    bit          same;
    logic [20:0] v0, v1, v2;
    logic [20:0] e0, e1, e2;
    logic [2:0]  emiss;
    logic [2:0]  erange;
  } vec_t;

  vec_t        tbl [9];
  logic [20:0] exp_l [3];

  function automatic vec_t mk(input logic [2:0] m, input bit s, input int v0, input int v1,
                              input int v2, input int e0, input int e1, input int e2,
                              input logic [2:0] em, input logic [2:0] er);
    vec_t r;
    r.mask = m; r.same = s;
    r.v0 = 21'(v0); r.v1 = 21'(v1); r.v2 = 21'(v2);
    r.e0 = 21'(e0); r.e1 = 21'(e1); r.e2 = 21'(e2);
    r.emiss = em; r.erange = er;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_strobes();
    bus.zhat_next_0_ap_vld = 1'b0;
    bus.zhat_next_1_ap_vld = 1'b0;
    bus.zhat_next_2_ap_vld = 1'b0;
  endtask

  task automatic set_strobe(input int k, input logic [20:0] val);
    case (k)
      0: begin bus.zhat_next_0 = val; bus.zhat_next_0_ap_vld = 1'b1; end
      1: begin bus.zhat_next_1 = val; bus.zhat_next_1_ap_vld = 1'b1; end
      default: begin bus.zhat_next_2 = val; bus.zhat_next_2_ap_vld = 1'b1; end
    endcase
  endtask

  task automatic handshake(input string tag);
    bus.state_ready = 1'b1;
    @(negedge ap_clk);
    bus.state_ready = 1'b0;
    chk({tag, " valid after accept"}, 32'(bus.state_valid), 32'd0);
    chk({tag, " busy after accept"}, 32'(busy), 32'd0);
  endtask

  // One estimator run; leaves the FSM in PRESENT when hold is set.
  task automatic run_vec(input int idx, input vec_t v, input bit hold);
    string t;
    logic [20:0] vals [3];
    t = $sformatf("v%0d", idx);
    vals[0] = v.v0; vals[1] = v.v1; vals[2] = v.v2;
    @(negedge ap_clk);
    trig = 1'b1;
    @(negedge ap_clk);
    trig = 1'b0;
    chk({t, " est_ap_start latency"}, 32'(bus.est_ap_start), 32'd1);
    bus.est_ap_ready = 1'b1;
    if (v.same) begin
      bus.est_ap_done = 1'b1;
      for (int k = 0; k < 3; k++) if (v.mask[k]) set_strobe(k, vals[k]);
    end else if (v.mask[0]) begin
      set_strobe(0, v.v0 ^ 21'h15555);
    end
    @(negedge ap_clk);
    bus.est_ap_ready = 1'b0;
    bus.est_ap_done  = 1'b0;
    clear_strobes();
    chk({t, " est_ap_start drop"}, 32'(bus.est_ap_start), 32'd0);
    if (!v.same) begin
      for (int k = 0; k < 3; k++) begin
        if (v.mask[k]) begin
          set_strobe(k, vals[k]);
          @(negedge ap_clk);
          clear_strobes();
        end
      end
      bus.est_ap_done = 1'b1;
      @(negedge ap_clk);
      bus.est_ap_done = 1'b0;
    end
    chk({t, " state_valid"}, 32'(bus.state_valid), 32'd1);
    chk({t, " state_0"}, 32'(bus.state_0), 32'(v.e0));
    chk({t, " state_1"}, 32'(bus.state_1), 32'(v.e1));
    chk({t, " state_2"}, 32'(bus.state_2), 32'(v.e2));
    chk({t, " missing"}, 32'(bus.missing), 32'(v.emiss));
`ifdef ZHAT_RANGE_CHECK_EN
    chk({t, " range_err"}, 32'(bus.range_err), 32'(v.erange));
`endif
    exp_l[0] = v.e0; exp_l[1] = v.e1; exp_l[2] = v.e2;
    if (!hold) handshake(t);
  endtask

  initial begin
    int n;
    bus.est_ap_ready = 1'b0;
    bus.est_ap_done  = 1'b0;
    bus.state_ready  = 1'b0;
    bus.zhat_next_0 = '0; bus.zhat_next_1 = '0; bus.zhat_next_2 = '0;
    clear_strobes();
    exp_l[0] = '0; exp_l[1] = '0; exp_l[2] = '0;

    //           mask   same v0       v1        v2      e0       e1        e2      miss    range
    tbl[0] = mk(3'b111, 0, 100,     -5,       7,      100,     -5,       7,      3'b000, 3'b000);
    tbl[1] = mk(3'b111, 0, 1,       2,        3,      1,       2,        3,      3'b000, 3'b000);
    tbl[2] = mk(3'b001, 0, 50,      0,        0,      50,      2,        3,      3'b110, 3'b000);
    tbl[3] = mk(3'b100, 1, 0,       0,        16384,  50,      2,        16384,  3'b011, 3'b000);
    tbl[4] = mk(3'b100, 1, 0,       0,        16385,  50,      2,        16385,  3'b011, 3'b100);
    tbl[5] = mk(3'b010, 0, 0,       -1048576, 0,      50,      -1048576, 16385,  3'b101, 3'b010);
    tbl[6] = mk(3'b000, 1, 0,       0,        0,      50,      -1048576, 16385,  3'b111, 3'b000);
    tbl[7] = mk(3'b111, 1, 1048575, 102944,   -16384, 1048575, 102944,   -16384, 3'b000, 3'b001);
    tbl[8] = mk(3'b111, 0, 163840,  -102945,  -16385, 163840,  -102945,  -16385, 3'b000, 3'b110);

    repeat (3) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (4) @(negedge ap_clk);
    chk("reset est_ap_start", 32'(bus.est_ap_start), 32'd0);
    chk("reset state_valid", 32'(bus.state_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset missing", 32'(bus.missing), 32'd0);
    chk("reset err_timeout", 32'(err_timeout), 32'd0);
    chk("reset err_overrun", 32'(err_overrun), 32'd0);
    chk("reset state_0", 32'(bus.state_0), 32'd0);

    for (int i = 0; i < 9; i++) run_vec(i, tbl[i], 1'b0);
    chk("no err_timeout after table", 32'(err_timeout), 32'd0);
    chk("no err_overrun after table", 32'(err_overrun), 32'd0);

    // Timeout: ready accepted, done never comes.
    @(negedge ap_clk);
    trig = 1'b1;
    @(negedge ap_clk);
    trig = 1'b0;
    bus.est_ap_ready = 1'b1;
    n = 0;
    do begin
      @(negedge ap_clk);
      bus.est_ap_ready = 1'b0;
      n++;
    end while (!bus.state_valid && n < 200);
    chk("timeout latency from START", 32'(n), 32'd64);
    chk("timeout err_timeout", 32'(err_timeout), 32'd1);
    chk("timeout missing", 32'(bus.missing), 32'd7);
    chk("timeout state_1 kept", 32'(bus.state_1), 32'(exp_l[1]));
    handshake("timeout");
    run_vec(100, tbl[0], 1'b0);
    chk("err_timeout sticky", 32'(err_timeout), 32'd1);

    // Backpressure with a dropped trig and an ignored strobe while presenting.
    run_vec(101, tbl[1], 1'b1);
    for (int c = 0; c < 10; c++) begin
      @(negedge ap_clk);
      chk($sformatf("hold c%0d state_valid", c), 32'(bus.state_valid), 32'd1);
      chk($sformatf("hold c%0d state_0", c), 32'(bus.state_0), 32'(exp_l[0]));
      chk($sformatf("hold c%0d est_ap_start", c), 32'(bus.est_ap_start), 32'd0);
      trig = (c == 5);
      clear_strobes();
      if (c == 3) set_strobe(0, 21'h0AAAA);
    end
    @(negedge ap_clk);
    trig = 1'b0;
    clear_strobes();
    chk("hold missing", 32'(bus.missing), 32'd0);
    chk("overrun flag", 32'(err_overrun), 32'd1);
    chk("strobe in PRESENT ignored", 32'(bus.state_0), 32'(exp_l[0]));
    handshake("hold");
    set_strobe(1, 21'h12345);
    @(negedge ap_clk);
    clear_strobes();
    repeat (2) @(negedge ap_clk);
    chk("dropped trig no start", 32'(bus.est_ap_start), 32'd0);
    chk("dropped trig idle", 32'(busy), 32'd0);
    chk("strobe in IDLE ignored", 32'(bus.state_1), 32'(exp_l[1]));

    // Trig coinciding with the PRESENT accept is dropped.
    run_vec(102, tbl[2], 1'b1);
    bus.state_ready = 1'b1;
    trig = 1'b1;
    @(negedge ap_clk);
    bus.state_ready = 1'b0;
    trig = 1'b0;
    chk("accept+trig valid", 32'(bus.state_valid), 32'd0);
    chk("accept+trig start", 32'(bus.est_ap_start), 32'd0);
    @(negedge ap_clk);
    chk("accept+trig no restart", 32'(bus.est_ap_start), 32'd0);
    chk("accept+trig idle", 32'(busy), 32'd0);

    // Asynchronous reset during START, then during COLLECT.
    @(negedge ap_clk);
    trig = 1'b1;
    @(negedge ap_clk);
    trig = 1'b0;
    chk("pre-reset start", 32'(bus.est_ap_start), 32'd1);
    #2 ap_rst_n = 1'b0;
    #1 chk("reset in START drops start", 32'(bus.est_ap_start), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    run_vec(103, tbl[1], 1'b0);
    chk("overrun cleared by reset", 32'(err_overrun), 32'd0);
    @(negedge ap_clk);
    trig = 1'b1;
    @(negedge ap_clk);
    trig = 1'b1;
    bus.est_ap_ready = 1'b1;
    @(negedge ap_clk);
    trig = 1'b0;
    bus.est_ap_ready = 1'b0;
    chk("pre-reset busy", 32'(busy), 32'd1);
    chk("pre-reset err_overrun", 32'(err_overrun), 32'd1);
    #2 ap_rst_n = 1'b0;
    #1;
    chk("async reset busy", 32'(busy), 32'd0);
    chk("async reset start", 32'(bus.est_ap_start), 32'd0);
    chk("async reset valid", 32'(bus.state_valid), 32'd0);
    chk("async reset err_overrun", 32'(err_overrun), 32'd0);
    chk("async reset err_timeout", 32'(err_timeout), 32'd0);
    chk("async reset state_0", 32'(bus.state_0), 32'd0);
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    repeat (3) @(negedge ap_clk);
    chk("post-reset idle", 32'(busy), 32'd0);
    run_vec(104, tbl[0], 1'b0);
    chk("post-reset no overrun", 32'(err_overrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/estimador_zhat_collector.md
Name: estimador_zhat_collector

Overview:
- Initiator and consumer for the estimator clamp loop's ap_ctrl_hs handshake.
- On each sample tick it starts the estimator, then captures the three ap_vld-strobed 21-bit zhat_next lanes and waits for ap_done.
- It then presents the completed state vector downstream on a valid/ready interface.
- It tracks missing lanes, timeouts and tick overruns so the MPC loop never consumes a partial vector silently.

Parameters:
- W, 21, lane width (signed fixed point, matches zhat_next).
- TIMEOUT_CYC, 64, maximum cycles from ap_start assertion to ap_done before abort.
- CNT_W, 8, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous assert, active low.
- trig  in  1  sample tick, single-cycle pulse.
- est_ap_start  out  1  start request to estimator.
- est_ap_ready  in  1  estimator accepted start.
- est_ap_done  in  1  estimator finished.
- zhat_next_0 / zhat_next_1 / zhat_next_2  in  W each  lane data.
- zhat_next_0_ap_vld / zhat_next_1_ap_vld / zhat_next_2_ap_vld  in  1 each  lane strobes.
- state_0 / state_1 / state_2  out  W each  registered output vector.
- state_valid  out  1  vector available.
- state_ready  in  1  downstream accept.
- missing  out  3  per-lane "not refreshed this run" flags, valid with state_valid.
- err_timeout  out  1  sticky timeout flag.
- err_overrun  out  1  sticky dropped-trig flag.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, lane registers and timeout counter 0. ap_rst_n is asynchronous and active low; deassertion is synchronised internally to ap_clk. Reset mid-run aborts immediately: est_ap_start drops in the same cycle and no vector is presented.
- FSM states: IDLE, START, COLLECT, PRESENT.
- IDLE: a trig moves the FSM to START on the next edge and clears the per-lane got[2:0] flags.
- START: est_ap_start=1 (Moore). A cycle with est_ap_ready=1 moves to COLLECT. If est_ap_done is also high in that cycle, go directly to PRESENT.
- COLLECT: est_ap_start=0. est_ap_done=1 moves to PRESENT.
- Lane capture: in START and COLLECT, any cycle with zhat_next_k_ap_vld=1 loads state_k <= zhat_next_k and sets got[k]. The last strobe wins. A strobe in the same cycle as est_ap_done is captured.
- Strobes outside START and COLLECT are ignored.
- Timeout: the counter clears on entry to START and increments each cycle in START and COLLECT. When it reaches TIMEOUT_CYC-1 without est_ap_done, the FSM moves to PRESENT and err_timeout is set.
- err_timeout and err_overrun stay set until reset.
- PRESENT: state_valid=1 and missing = ~got. Lanes that were not refreshed keep their previous value. state_* and missing are stable while state_valid=1 and state_ready=0.
- state_valid=1 with state_ready=1 returns the FSM to IDLE on the next edge.
- Overrun: a trig in any state except IDLE is dropped and sets err_overrun. A trig in the same cycle as the PRESENT handshake completes is also dropped; there is no look-ahead restart.
- Latency: trig to est_ap_start is 1 cycle. est_ap_done to state_valid is 1 cycle.
- Arithmetic: none on the data path. Lanes are passed bit-exact as signed W-bit values.

Optional Feature:
- Macro: ZHAT_RANGE_CHECK_EN.
- When defined, the block adds an output range_err (3 bits), valid with state_valid. Bit k is set if the captured lane k value, read as signed, is outside the estimator clamp bounds:
  - lane0: [-163840, 163840]
  - lane1: [-102944, 102944]
  - lane2: [-16384, 16384]
- Bounds are inclusive. A lane flagged in missing reports range_err=0.
- When not defined, the port and all compare logic are absent, and the rest of the behaviour is identical.

Test Plan:
- Nominal run: trig; est_ap_ready in the START cycle; vld0=100, vld1=-5, vld2=7 on consecutive cycles; est_ap_done -> state_valid one cycle after done with state_0=100, state_1=-5, state_2=7, missing=000; state_ready=1 returns the FSM to IDLE.
- Missing lane: previous vector (1,2,3); new run strobes only lane0=50, then done -> output (50,2,3), missing=110 (lane2 is the MSB).
- Timeout: trig, est_ap_ready given, est_ap_done never asserted -> state_valid at 64 cycles after START entry, err_timeout=1 and sticky across the next successful run.
- Backpressure and overrun: state_ready held 0 for 10 cycles with a trig pulse in cycle 5 -> outputs held stable, err_overrun=1, no est_ap_start until the FSM returns to IDLE and a new trig arrives.
- Simultaneous events: est_ap_ready and est_ap_done high in the same cycle, together with vld2=16384 -> direct START-to-PRESENT transition, state_2=16384 captured. With ZHAT_RANGE_CHECK_EN, state_2=16385 gives range_err=100.
- Async reset: assert ap_rst_n low in the middle of COLLECT -> est_ap_start, state_valid and all flags go to 0 immediately, without waiting for a clock edge; after release and a trig, the next run starts cleanly.
